// File: rtl/hash160_host_feeder.sv
// hash160_host_feeder: collects a 1..55 byte message, applies SHA-256
// single-block padding, streams the block to the Hash160 core behind a
// start token, then waits for the core's done pulse (or a timeout) and
// holds the 160-bit digest behind a valid/ready result handshake.
module hash160_host_feeder #(
    parameter logic [7:0]  START_TOKEN = 8'hA5,
    parameter int unsigned TIMEOUT     = 32'd1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_data,
    input  logic         s_last,
    output logic [7:0]   h_text,
    input  logic         h_valid,
    input  logic [159:0] h_answer,
    output logic         r_valid,
    input  logic         r_ready,
    output logic [159:0] r_digest,
    output logic         r_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 32'd1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        SEND    = 3'd2,
        WAIT    = 3'd3,
        RESULT  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     len_q, len_d;
    logic           ovf_q, ovf_d;
    logic [6:0]     k_q, k_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     h_text_q, h_text_d;
    logic           s_ready_q, s_ready_d;
    logic           r_valid_q, r_valid_d;
    logic [159:0]   r_digest_q, r_digest_d;
    logic           r_err_q, r_err_d;
    logic [7:0]     msg_q [0:54];
    logic           wr_en_s;
    logic           accept_s;
    logic [5:0]     j_s;
    logic [7:0]     rd_byte_s;

    // Padded block byte j for a message of len bytes (bit length big-endian
    // in bytes 56..63; only the low 9 bits of len*8 can be nonzero).
    function automatic logic [7:0] pad_byte(input logic [5:0] j,
                                            input logic [5:0] len,
                                            input logic [7:0] data);
        logic [7:0] b;
        if (j < len) begin
            b = data;
        end else if (j == len) begin
            b = 8'h80;
        end else if (j < 6'd62) begin
            b = 8'h00;
        end else if (j == 6'd62) begin
            b = {7'd0, len[5]};
        end else begin
            b = {len[4:0], 3'b000};
        end
        return b;
    endfunction

    assign accept_s  = s_valid && s_ready_q;
    assign j_s       = k_q[5:0] - 6'd1;
    assign rd_byte_s = (j_s < 6'd55) ? msg_q[j_s] : 8'h00;

    assign s_ready  = s_ready_q;
    assign h_text   = h_text_q;
    assign r_valid  = r_valid_q;
    assign r_digest = r_digest_q;
    assign r_err    = r_err_q;

    // Message buffer: data storage only, written while collecting.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            msg_q[len_q] <= s_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= 6'd0;
            ovf_q      <= 1'b0;
            k_q        <= 7'd0;
            timer_q    <= '0;
            h_text_q   <= 8'h00;
            s_ready_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            r_digest_q <= 160'd0;
            r_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            k_q        <= k_d;
            timer_q    <= timer_d;
            h_text_q   <= h_text_d;
            s_ready_q  <= s_ready_d;
            r_valid_q  <= r_valid_d;
            r_digest_q <= r_digest_d;
            r_err_q    <= r_err_d;
        end
    end

    // Next-state and next-output logic; h_text defaults to 0 so the core
    // only ever sees bytes while SEND is active.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        k_d        = k_q;
        timer_d    = timer_q;
        h_text_d   = 8'h00;
        s_ready_d  = s_ready_q;
        r_valid_d  = r_valid_q;
        r_digest_d = r_digest_q;
        r_err_d    = r_err_q;
        wr_en_s    = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                s_ready_d = 1'b1;
                if (accept_s) begin
                    if (ovf_q || (len_q == 6'd55)) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_s = 1'b1;
                        len_d   = len_q + 6'd1;
                    end
                    if (s_last) begin
                        s_ready_d = 1'b0;
                        if (ovf_d) begin
                            state_d    = RESULT;
                            r_valid_d  = 1'b1;
                            r_err_d    = 1'b1;
                            r_digest_d = 160'd0;
                        end else begin
                            state_d  = SEND;
                            k_d      = 7'd1;
                            h_text_d = START_TOKEN;
                        end
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            SEND: begin
                if (k_q == 7'd65) begin
                    state_d = WAIT;
                    timer_d = '0;
                end else begin
                    h_text_d = pad_byte(j_s, len_q, rd_byte_s);
                    k_d      = k_q + 7'd1;
                end
            end
            WAIT: begin
                if (h_valid) begin
                    state_d    = RESULT;
                    r_valid_d  = 1'b1;
                    r_digest_d = h_answer;
                    r_err_d    = 1'b0;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    state_d    = RESULT;
                    r_valid_d  = 1'b1;
                    r_digest_d = 160'd0;
                    r_err_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESULT: begin
                if (r_ready) begin
                    state_d   = IDLE;
                    r_valid_d = 1'b0;
                    len_d     = 6'd0;
                    ovf_d     = 1'b0;
                    timer_d   = '0;
                    s_ready_d = 1'b1;
                end else begin
                    r_valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                s_ready_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hash160_host_feeder.sv
// Directed bench for hash160_host_feeder. dut_a uses the default timeout,
// dut_t a 20-cycle timeout; both see the same message stream.
module tb_hash160_host_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid, s_last, r_ready;
    logic [7:0]   s_data;
    logic         h_valid_a, h_valid_t;
    logic [159:0] h_answer;
    logic         s_ready_a, r_valid_a, r_err_a;
    logic [7:0]   h_text_a;
    logic [159:0] r_digest_a;
    logic         s_ready_t, r_valid_t, r_err_t;
    logic [7:0]   h_text_t;
    logic [159:0] r_digest_t;

    int checks = 0;
    int errors = 0;
    int nz_cnt = 0;
    logic mon_en = 1'b0;
    logic [7:0] msg [0:63];
    logic [7:0] got [0:65];

    localparam logic [159:0] ANS1 = 160'h0123456789abcdef0123456789abcdef01234567;
    localparam logic [159:0] ANS2 = 160'hfedcba9876543210fedcba9876543210fedcba98;
    localparam logic [159:0] ANS3 = 160'h5555aaaa5555aaaa5555aaaa5555aaaa5555aaaa;
    localparam logic [159:0] ANS4 = 160'h00000000000000000000000000000000deadbeef;

    always #5 clk = ~clk;

    hash160_host_feeder dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_data(s_data), .s_last(s_last), .h_text(h_text_a), .h_valid(h_valid_a),
        .h_answer(h_answer), .r_valid(r_valid_a), .r_ready(r_ready),
        .r_digest(r_digest_a), .r_err(r_err_a)
    );

    hash160_host_feeder #(.START_TOKEN(8'hA5), .TIMEOUT(32'd20)) dut_t (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_t),
        .s_data(s_data), .s_last(s_last), .h_text(h_text_t), .h_valid(h_valid_t),
        .h_answer(h_answer), .r_valid(r_valid_t), .r_ready(r_ready),
        .r_digest(r_digest_t), .r_err(r_err_t)
    );

    // Count any non-idle core byte while monitoring is enabled.
    always @(negedge clk) begin
        if (mon_en && ((h_text_a != 8'h00) || (h_text_t != 8'h00))) begin
            nz_cnt <= nz_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected padded byte: message, 0x80, zeros, 64-bit big-endian bit count.
    function automatic logic [7:0] exp_byte(input int n, input int j);
        logic [63:0] bits;
        bits = 64'(n) * 64'd8;
        if (j < n) return msg[j];
        else if (j == n) return 8'h80;
        else if (j < 56) return 8'h00;
        else return bits[8*(63-j) +: 8];
    endfunction

    task automatic push_byte(input logic [7:0] d, input logic l, input logic gaps);
        int n;
        int g;
        if (gaps) begin
            g = int'($urandom_range(0, 2));
            repeat (g) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        s_valid = 1'b1; s_data = d; s_last = l; n = 0;
        while (s_ready_a !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("push_stall", 160'(s_ready_a), 160'(1'b1));
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_msg(input int n, input logic gaps);
        for (int i = 0; i < n - 1; i++) push_byte(msg[i], 1'b0, gaps);
        check_eq("pre_last_htext", 160'(h_text_a), 160'(8'h00));
        check_eq("pre_last_rvalid", 160'(r_valid_a), 160'(1'b0));
        push_byte(msg[n-1], 1'b1, gaps);
    endtask

    task automatic capture();
        got[0] = h_text_a;
        for (int i = 1; i < 66; i++) begin
            @(negedge clk);
            got[i] = h_text_a;
        end
    endtask

    task automatic verify_block(input string name, input int n);
        check_eq({name, "_token"}, 160'(got[0]), 160'(8'hA5));
        for (int j = 0; j < 64; j++)
            check_eq($sformatf("%s_b%0d", name, j), 160'(got[j+1]), 160'(exp_byte(n, j)));
        check_eq({name, "_idle_after"}, 160'(got[65]), 160'(8'h00));
    endtask

    task automatic respond(input int dly, input logic [159:0] ans, input logic both);
        repeat (dly) @(negedge clk);
        check_eq("rsp_pre_rvalid", 160'(r_valid_a), 160'(1'b0));
        h_answer = ans; h_valid_a = 1'b1; h_valid_t = both;
        @(negedge clk);
        h_valid_a = 1'b0; h_valid_t = 1'b0; h_answer = ~ans;
        check_eq("rsp_rvalid", 160'(r_valid_a), 160'(1'b1));
        check_eq("rsp_digest", r_digest_a, ans);
        check_eq("rsp_err", 160'(r_err_a), 160'(1'b0));
    endtask

    task automatic handshake();
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check_eq("hs_rvalid_a", 160'(r_valid_a), 160'(1'b0));
        check_eq("hs_sready_a", 160'(s_ready_a), 160'(1'b1));
        check_eq("hs_rvalid_t", 160'(r_valid_t), 160'(1'b0));
        check_eq("hs_sready_t", 160'(s_ready_t), 160'(1'b1));
    endtask

    task automatic load_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        r_ready = 1'b0; h_valid_a = 1'b0; h_valid_t = 1'b0; h_answer = 160'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_sready", 160'(s_ready_a), 160'(1'b0));
        check_eq("rst_htext", 160'(h_text_a), 160'(8'h00));
        check_eq("rst_rvalid", 160'(r_valid_a), 160'(1'b0));
        check_eq("rst_digest", r_digest_a, 160'd0);
        check_eq("rst_err", 160'(r_err_a), 160'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_sready", 160'(s_ready_a), 160'(1'b1));

        // "abc" with back-pressure on the result
        load_abc();
        send_msg(3, 1'b0);
        capture();
        verify_block("abc", 3);
        check_eq("abc_pad80", 160'(got[4]), 160'(8'h80));
        check_eq("abc_b62", 160'(got[63]), 160'(8'h00));
        check_eq("abc_b63", 160'(got[64]), 160'(8'h18));
        respond(99, ANS1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("bp_rvalid", 160'(r_valid_a), 160'(1'b1));
            check_eq("bp_digest", r_digest_a, ANS1);
            check_eq("bp_sready", 160'(s_ready_a), 160'(1'b0));
        end
        check_eq("abc_t_err", 160'(r_err_t), 160'(1'b1));
        check_eq("abc_t_digest", r_digest_t, 160'd0);
        handshake();

        // 55-byte message 00..36 with random s_valid gaps
        for (int i = 0; i < 55; i++) msg[i] = 8'(i);
        send_msg(55, 1'b1);
        capture();
        verify_block("m55", 55);
        check_eq("m55_pad80", 160'(got[56]), 160'(8'h80));
        check_eq("m55_b62", 160'(got[63]), 160'(8'h01));
        check_eq("m55_b63", 160'(got[64]), 160'(8'hB8));
        respond(5, ANS2, 1'b1);
        handshake();

        // 56-byte overflow, then "x"
        for (int i = 0; i < 56; i++) msg[i] = 8'(i + 1);
        nz_cnt = 0;
        mon_en = 1'b1;
        send_msg(56, 1'b0);
        check_eq("ovf_rvalid", 160'(r_valid_a), 160'(1'b1));
        check_eq("ovf_err", 160'(r_err_a), 160'(1'b1));
        check_eq("ovf_digest", r_digest_a, 160'd0);
        check_eq("ovf_rvalid_t", 160'(r_valid_t), 160'(1'b1));
        handshake();
        @(negedge clk);
        mon_en = 1'b0;
        check_eq("ovf_no_htext", 160'(nz_cnt), 160'd0);
        msg[0] = 8'h78;
        send_msg(1, 1'b0);
        capture();
        verify_block("x", 1);
        check_eq("x_b0", 160'(got[1]), 160'(8'h78));
        check_eq("x_pad80", 160'(got[2]), 160'(8'h80));
        check_eq("x_b63", 160'(got[64]), 160'(8'h08));
        respond(3, ANS3, 1'b1);
        handshake();

        // Timeout on dut_t (20 cycles), late h_valid ignored
        msg[0] = 8'h5A;
        send_msg(1, 1'b0);
        capture();
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            check_eq($sformatf("to_rvalid_c%0d", c), 160'(r_valid_t), 160'(c == 21));
        end
        check_eq("to_err", 160'(r_err_t), 160'(1'b1));
        check_eq("to_digest", r_digest_t, 160'd0);
        h_answer = ANS4; h_valid_t = 1'b1;
        @(negedge clk);
        h_valid_t = 1'b0;
        @(negedge clk);
        check_eq("late_digest", r_digest_t, 160'd0);
        check_eq("late_err", 160'(r_err_t), 160'(1'b1));
        check_eq("late_rvalid", 160'(r_valid_t), 160'(1'b1));
        respond(2, ANS4, 1'b0);
        handshake();

        // Reset in the middle of SEND
        for (int i = 0; i < 40; i++) msg[i] = 8'(8'h11 + 8'(i));
        send_msg(40, 1'b0);
        repeat (30) @(negedge clk);
        check_eq("mid_send_busy", 160'(h_text_a != 8'h00), 160'(1'b1));
        rst_n = 1'b0;
        #1;
        check_eq("mrst_htext", 160'(h_text_a), 160'(8'h00));
        check_eq("mrst_sready", 160'(s_ready_a), 160'(1'b0));
        check_eq("mrst_rvalid", 160'(r_valid_a), 160'(1'b0));
        check_eq("mrst_digest", r_digest_a, 160'd0);
        check_eq("mrst_err", 160'(r_err_a), 160'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_post_sready", 160'(s_ready_a), 160'(1'b1));
        check_eq("mrst_post_htext", 160'(h_text_a), 160'(8'h00));
        load_abc();
        send_msg(3, 1'b0);
        capture();
        verify_block("abc2", 3);
        respond(4, ANS1, 1'b1);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
